// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite to FIFO bridge: response codes,
// FSM state encodings and the status register word offset.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] RESP_SLVERR   = 2'b10;

    // araddr[3:2] value selecting the status word (only when STATUS_REG_EN)
    localparam logic [1:0] STATUS_OFFSET = 2'b01;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_PUSH = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_POP  = 2'd1,
        R_WAIT = 2'd2,
        R_RESP = 2'd3
    } r_state_t;

endpackage

// File: rtl/axi4_lite_chan_capture.sv
// Single-entry valid/ready capture register for one AXI channel (AW or W).
// Ready is registered: it is high whenever the slot is empty, drops the
// cycle after a handshake and returns the cycle after the slot is released.
module axi4_lite_chan_capture #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         arestn,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_release,
    output logic         o_ready,
    output logic         o_hs,
    output logic         o_full,
    output logic [W-1:0] o_data
);

    logic         r_ready;
    logic         r_full;
    logic [W-1:0] r_data;

    assign o_hs   = i_valid & r_ready;
    assign o_ready = r_ready;
    assign o_full  = r_full;
    assign o_data  = r_data;

    // Slot state: capture on handshake, empty on release, re-arm ready when empty
    always_ff @(posedge clk or negedge arestn) begin
        if (!arestn) begin
            r_ready <= 1'b0;
            r_full  <= 1'b0;
            r_data  <= '0;
        end else if (o_hs) begin
            r_data  <= i_data;
            r_full  <= 1'b1;
            r_ready <= 1'b0;
        end else if (i_release) begin
            r_full  <= 1'b0;
            r_ready <= 1'b1;
        end else if (!r_full) begin
            r_ready <= 1'b1;
        end
    end

endmodule

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite slave bridging writes to a sink FIFO push ({awaddr, wdata}) and
// reads to a source FIFO pop. Write and read paths are independent FSMs.
// Optional build macro STATUS_REG_EN: reads with araddr[3:2]==STATUS_OFFSET
// return {.., full, empty} without popping the source FIFO.
module axi4_lite_slave
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     arestn,
    // read address / data channels
    input  logic [ADDR_W-1:0]        araddr,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [DATA_W-1:0]        rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready,
    // write address / data / response channels
    input  logic [ADDR_W-1:0]        awaddr,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    // source FIFO (pop side)
    output logic                     read_en,
    input  logic [DATA_W-1:0]        read_data,
    input  logic                     empty,
    // sink FIFO (push side)
    output logic                     write_en,
    output logic [ADDR_W+DATA_W-1:0] write_data,
    input  logic                     full
);

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    w_state_t            r_wstate;
    w_state_t            w_wstate_nxt;
    logic                r_full_q;
    logic                w_push;
    logic                w_release;
    logic                w_aw_hs;
    logic                w_aw_full;
    logic [ADDR_W-1:0]   w_aw_q;
    logic                w_w_hs;
    logic                w_w_full;
    logic [DATA_W-1:0]   w_w_q;

    assign w_release = (r_wstate == W_RESP) && bready;

    axi4_lite_chan_capture #(.W(ADDR_W)) u_aw_cap (
        .clk       (clk),
        .arestn    (arestn),
        .i_valid   (awvalid),
        .i_data    (awaddr),
        .i_release (w_release),
        .o_ready   (awready),
        .o_hs      (w_aw_hs),
        .o_full    (w_aw_full),
        .o_data    (w_aw_q)
    );

    axi4_lite_chan_capture #(.W(DATA_W)) u_w_cap (
        .clk       (clk),
        .arestn    (arestn),
        .i_valid   (wvalid),
        .i_data    (wdata),
        .i_release (w_release),
        .o_ready   (wready),
        .o_hs      (w_w_hs),
        .o_full    (w_w_full),
        .o_data    (w_w_q)
    );

    // Write FSM next state; push only when full is low now and was low last
    // cycle, so the strobe lands one cycle after full falls and never into a
    // FIFO that just filled.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_push       = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if ((w_aw_full || w_aw_hs) && (w_w_full || w_w_hs))
                    w_wstate_nxt = W_PUSH;
            end
            W_PUSH: begin
                if (!full && !r_full_q) begin
                    w_push       = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (bready)
                    w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Write FSM state and delayed copy of full
    always_ff @(posedge clk or negedge arestn) begin
        if (!arestn) begin
            r_wstate <= W_IDLE;
            r_full_q <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_full_q <= full;
        end
    end

    assign write_en   = w_push;
    assign write_data = {w_aw_q, w_w_q};
    assign bvalid     = (r_wstate == W_RESP);
    assign bresp      = RESP_OKAY;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    r_state_t            r_rstate;
    r_state_t            w_rstate_nxt;
    logic                r_arready;
    logic [ADDR_W-1:0]   r_araddr;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_rresp;
    logic                w_ar_hs;
    logic                w_pop;
    logic                w_status;

    assign w_ar_hs = arvalid && r_arready;

`ifdef STATUS_REG_EN
    assign w_status = (r_araddr[3:2] == STATUS_OFFSET);
`else
    logic w_unused_araddr;
    assign w_status        = 1'b0;
    assign w_unused_araddr = ^r_araddr;
`endif

    // Read FSM next state; status reads and empty FIFO skip the pop
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_pop        = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_hs)
                    w_rstate_nxt = R_POP;
            end
            R_POP: begin
                if (w_status || empty) begin
                    w_rstate_nxt = R_RESP;
                end else begin
                    w_pop        = 1'b1;
                    w_rstate_nxt = R_WAIT;
                end
            end
            R_WAIT:  w_rstate_nxt = R_RESP;
            R_RESP: begin
                if (rready)
                    w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Read FSM state, registered arready and address capture
    always_ff @(posedge clk or negedge arestn) begin
        if (!arestn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_araddr  <= '0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= (w_rstate_nxt == R_IDLE);
            if (w_ar_hs)
                r_araddr <= araddr;
        end
    end

    // Read response payload; held untouched through R_RESP
    always_ff @(posedge clk or negedge arestn) begin
        if (!arestn) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (r_rstate == R_POP) begin
            if (w_status) begin
                r_rdata <= {{(DATA_W-2){1'b0}}, full, empty};
                r_rresp <= RESP_OKAY;
            end else if (empty) begin
                r_rdata <= '0;
                r_rresp <= RESP_SLVERR;
            end
        end else if (r_rstate == R_WAIT) begin
            r_rdata <= read_data;
            r_rresp <= RESP_OKAY;
        end
    end

    assign arready = r_arready;
    assign read_en = w_pop;
    assign rvalid  = (r_rstate == R_RESP);
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Scoreboard bench for axi4_lite_slave: directed scenarios then concurrent
// randomized write/read traffic with random backpressure.
module tb_axi4_lite_slave;

    logic        clk, arestn;
    logic [31:0] araddr, rdata, awaddr, wdata, read_data;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        read_en, empty, write_en, full;
    logic [63:0] write_data;

    axi4_lite_slave #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .arestn(arestn),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .read_en(read_en), .read_data(read_data), .empty(empty),
        .write_en(write_en), .write_data(write_data), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [63:0] exp_w[$];   // expected pushes {addr, data}
    logic [33:0] exp_r[$];   // expected read responses {resp, data}
    int          exp_b = 0;  // outstanding write responses
    logic [31:0] src_q[$];   // source FIFO contents
    int          rd_done = 0;
    logic        rand_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return write_en;
            1:       return bvalid;
            2:       return read_en;
            default: return rvalid;
        endcase
    endfunction

    // negedges until the selected output is seen high; 999 on timeout
    task automatic wait_for(input int which, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sel(which) && n < 50);
        if (!sel(which)) n = 999;
    endtask

    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        awaddr = a; awvalid = 1'b1;
        @(negedge clk);
        while (!awready && n < 300) begin @(negedge clk); n++; end
        if (!awready) fail_now("aw_timeout");
        else @(posedge clk);
        #1 awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d);
        int n = 0;
        wdata = d; wvalid = 1'b1;
        @(negedge clk);
        while (!wready && n < 300) begin @(negedge clk); n++; end
        if (!wready) fail_now("w_timeout");
        else @(posedge clk);
        #1 wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n = 0;
        araddr = a; arvalid = 1'b1;
        @(negedge clk);
        while (!arready && n < 300) begin @(negedge clk); n++; end
        if (!arready) fail_now("ar_timeout");
        else @(posedge clk);
        #1 arvalid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {awready, wready, arready, bvalid, rvalid, write_en, read_en, bresp, rresp}, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_wdata"}, write_data, 0);
    endtask

    // Monitor: scoreboard pops, FIFO model and protocol rules
    initial begin : monitor
        logic        hold;
        logic [33:0] held;
        hold = 1'b0; held = '0;
        read_data = '0;
        forever begin
            @(negedge clk);
            if (!arestn) begin
                hold = 1'b0;
            end else begin
                if (write_en) begin
                    chk("we_while_full", full, 0);
                    if (exp_w.size() == 0) fail_now("we_unexpected");
                    else chk("write_data", write_data, exp_w.pop_front());
                end
                if (bvalid && bready) begin
                    if (exp_b == 0) fail_now("b_unexpected");
                    else begin exp_b--; chk("bresp", bresp, 0); end
                end
                if (read_en) begin
                    chk("re_while_empty", empty, 0);
                    if (src_q.size() == 0) begin fail_now("re_src_underflow"); read_data = '0; end
                    else read_data = src_q.pop_front();
                end
                if (hold) chk("r_stable", {rvalid, rresp, rdata}, {1'b1, held});
                if (rvalid && rready) begin
                    if (exp_r.size() == 0) fail_now("r_unexpected");
                    else chk("rresp_rdata", {rresp, rdata}, exp_r.pop_front());
                    rd_done++;
                end
                hold = rvalid && !rready;
                held = {rresp, rdata};
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin : stim
        int n;
        arestn = 1'b0;
        araddr = '0; arvalid = 0; rready = 0;
        awaddr = '0; awvalid = 0; wdata = '0; wvalid = 0; bready = 0;
        empty = 1'b1; full = 1'b0;

        // reset state and ready rise after release
        #3 chk_all_zero("reset");
        repeat (2) @(negedge clk);
        arestn = 1'b1;
        #1 chk("ready_before_clk", {awready, wready, arready}, 3'b000);
        @(posedge clk); #1;
        chk("ready_after_clk", {awready, wready, arready}, 3'b111);
        bready = 1; rready = 1;

        // T1: simultaneous AW/W
        exp_w.push_back(64'hA5A5A5A5B5B5B5B5); exp_b++;
        fork send_aw(32'hA5A5A5A5); send_w(32'hB5B5B5B5); join
        wait_for(0, n); chk("t1_we_lat", n, 1);
        wait_for(1, n); chk("t1_bv_lat", n, 1);
        @(negedge clk); chk("t1_bv_one_cycle", bvalid, 0);

        // T2: AW two cycles ahead of W
        @(posedge clk); #1;
        exp_w.push_back(64'h12345678_9ABCDEF0); exp_b++;
        fork
            begin
                send_aw(32'h12345678);
                @(negedge clk);
                chk("t2_awready_low", awready, 0);
                chk("t2_no_early_we", write_en, 0);
            end
            begin
                repeat (2) @(posedge clk); #1;
                send_w(32'h9ABCDEF0);
            end
        join
        wait_for(0, n); chk("t2_we_lat", n, 1);
        wait_for(1, n); chk("t2_bv_lat", n, 1);

        // T3: stall on full for 5 cycles
        @(posedge clk); #1;
        full = 1'b1;
        exp_w.push_back(64'h0000_0040_DEAD_BEEF); exp_b++;
        fork send_aw(32'h40); send_w(32'hDEADBEEF); join
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_stall_quiet", {write_en, bvalid}, 2'b00);
        end
        @(posedge clk); #1 full = 1'b0;
        @(negedge clk); chk("t3_no_we_same_cycle", write_en, 0);
        @(negedge clk); chk("t3_we_after_full_fall", write_en, 1);
        wait_for(1, n); chk("t3_bv_lat", n, 1);

        // T4: read with rready held low 3 cycles
        @(posedge clk); #1;
        rready = 0; empty = 0;
        src_q.push_back(32'hCAFEF00D);
        exp_r.push_back({2'b00, 32'hCAFEF00D});
        send_ar(32'hA5A5A5A5);
        wait_for(2, n); chk("t4_re_lat", n, 1);
        wait_for(3, n); chk("t4_rv_lat", n, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_rv_held", {rvalid, rresp, rdata}, {1'b1, 2'b00, 32'hCAFEF00D});
        end
        @(posedge clk); #1 rready = 1;
        @(negedge clk);
        @(negedge clk); chk("t4_rv_drop", rvalid, 0);

        // T5: read with empty FIFO
        @(posedge clk); #1;
        empty = 1;
        exp_r.push_back({2'b10, 32'h0});
        send_ar(32'h00000100);
        wait_for(3, n); chk("t5_rv_lat", n, 2);
        @(negedge clk);

        // T6: reset during W_PUSH and R_WAIT
        @(posedge clk); #1;
        full = 1;
        fork send_aw(32'h11112222); send_w(32'h33334444); join
        empty = 0;
        src_q.push_back(32'h55556666);
        send_ar(32'h0);
        wait_for(2, n); chk("t6_re_lat", n, 1);
        @(posedge clk); #2 arestn = 1'b0;
        #1 chk_all_zero("t6_reset");
        full = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_in_reset_quiet", {write_en, read_en, bvalid, rvalid}, 4'b0);
        end
        @(negedge clk); #1 arestn = 1'b1;
        #1 chk("t6_ready_before_clk", {awready, wready, arready}, 3'b000);
        @(posedge clk); #1;
        chk("t6_ready_after_clk", {awready, wready, arready}, 3'b111);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_post_reset_quiet", {write_en, read_en, bvalid, rvalid}, 4'b0);
        end

        // Random concurrent traffic
        @(posedge clk); #1;
        rand_on = 1'b1;
        fork
            while (rand_on) begin
                @(posedge clk); #1;
                if (rand_on) begin
                    bready = 1'($urandom_range(0, 1));
                    rready = 1'($urandom_range(0, 1));
                    full   = ($urandom_range(0, 2) == 0);
                end
            end
        join_none
        fork
            begin : wr_thread
                for (int k = 0; k < 30; k++) begin
                    logic [31:0] a, d;
                    int mode, dly;
                    a = $urandom; d = $urandom;
                    mode = $urandom_range(0, 2);
                    dly  = $urandom_range(1, 3);
                    exp_w.push_back({a, d}); exp_b++;
                    case (mode)
                        0: fork send_aw(a); send_w(d); join
                        1: fork send_aw(a); begin repeat (dly) @(posedge clk); #1 send_w(d); end join
                        default: fork send_w(d); begin repeat (dly) @(posedge clk); #1 send_aw(a); end join
                    endcase
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
            end
            begin : rd_thread
                for (int k = 0; k < 30; k++) begin
                    logic emp;
                    int start, t;
                    if ($urandom_range(0, 3) == 0) src_q.push_back($urandom);
                    emp = ($urandom_range(0, 3) == 0) || (src_q.size() == 0);
                    empty = emp;
                    if (emp) exp_r.push_back({2'b10, 32'h0});
                    else     exp_r.push_back({2'b00, src_q[0]});
                    start = rd_done;
                    send_ar({$urandom} & 32'hFFFF_FFF3);
                    t = 0;
                    while (rd_done == start && t < 500) begin @(negedge clk); t++; end
                    if (rd_done == start) fail_now("rd_rand_timeout");
                    @(posedge clk); #1;
                end
            end
        join
        rand_on = 1'b0;
        repeat (2) @(posedge clk);
        #2 bready = 1; rready = 1; full = 0;

        // drain and final scoreboard state
        for (int i = 0; i < 500 && (exp_w.size() != 0 || exp_r.size() != 0 || exp_b != 0); i++)
            @(negedge clk);
        chk("drain_w", exp_w.size(), 0);
        chk("drain_b", exp_b, 0);
        chk("drain_r", exp_r.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave.md
Name: axi4_lite_slave

Overview:
AXI4-Lite slave that bridges AXI write and read transactions onto FIFO-style push and pop interfaces.
- A write pushes one 64-bit entry {awaddr, wdata} into a downstream FIFO.
- A read pops one 32-bit word from an upstream FIFO and returns it on the R channel.
- It sits between an AXI-Lite master (the NoC network interface) and the router ingress/egress FIFOs.

Parameters:
ADDR_W, 32, AXI address width.
DATA_W, 32, AXI data width; write_data width = ADDR_W+DATA_W.

Ports:
clk  in  1  system clock, all logic on posedge
arestn  in  1  asynchronous active-low reset
araddr  in  ADDR_W  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_W  read data
rresp  out  2  read response
rvalid  out  1  read data valid
rready  in  1  master ready for read data
awaddr  in  ADDR_W  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_W  write data
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  master ready for response
read_en  out  1  one-cycle pop strobe to source FIFO
read_data  in  DATA_W  source FIFO data, valid the cycle after read_en
empty  in  1  source FIFO empty
write_en  out  1  one-cycle push strobe to sink FIFO
write_data  out  ADDR_W+DATA_W  push data {awaddr, wdata}
full  in  1  sink FIFO full

Behaviour:
- Reset (arestn=0, asynchronous): all outputs 0, both state machines to IDLE, capture registers cleared, any in-flight transaction dropped with no strobe issued.
- Readies are registered and rise in the first clock after reset release.
- Write and read paths are independent and may run concurrently.
- Write FSM states: W_IDLE, W_PUSH, W_RESP.
  - W_IDLE: awready=1 until the address is captured; wready=1 until the data is captured. AW and W may arrive in the same cycle or in either order.
  - A handshake occurs at a posedge with valid&&ready. The captured channel's ready drops the next cycle.
  - When both are captured, go to W_PUSH.
  - W_PUSH: while full=1, wait with no strobe. When full=0, pulse write_en for exactly 1 cycle with write_data={awaddr_q, wdata_q}, then go to W_RESP.
  - W_RESP: bvalid=1, bresp=2'b00 (OKAY), held until bready. On handshake, bvalid drops and the FSM returns to W_IDLE (readies high the next cycle).
- Read FSM states: R_IDLE, R_POP, R_WAIT, R_RESP.
  - R_IDLE: arready=1. On handshake, capture araddr, drop arready, go to R_POP.
  - R_POP: if empty=1, load rdata=0, rresp=2'b10 (SLVERR), no read_en, go to R_RESP. Else pulse read_en for 1 cycle and go to R_WAIT.
  - R_WAIT: capture read_data into rdata, rresp=2'b00, go to R_RESP.
  - R_RESP: rvalid=1, rdata/rresp stable until rready. On handshake, go to R_IDLE.
- Latency (ready master, FIFO not empty/full):
  - Write: write_en 1 cycle after both captured; bvalid the cycle after write_en.
  - Read: read_en 1 cycle after AR handshake; rvalid 2 cycles after read_en.
- Address bits are otherwise ignored, except for the optional feature below.
- Exactly one write_en per AW/W pair and at most one read_en per AR.

Optional Feature:
STATUS_REG_EN:
- Defined: a read with araddr[3:2]==2'b01 returns rdata={30'b0, full, empty} with rresp=OKAY. It never pulses read_en and goes R_POP->R_RESP directly.
- Undefined: all addresses pop the FIFO as above.

Decomposition:
- Shared package axi4_lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, write/read state enum typedefs, STATUS_OFFSET constant.
- One natural sub-module: axi4_lite_chan_capture, a valid/ready capture register reused for the AW and W channels.
- Read FSM stays inline.

Test Plan:
- Simultaneous AW/W (awaddr=32'hA5A5A5A5, wdata=32'hB5B5B5B5, full=0, bready=1) -> single write_en, write_data=64'hA5A5A5A5B5B5B5B5, then bvalid=1 with bresp=00 for 1 cycle.
- AW two cycles before W -> awready low after the AW handshake, no write_en until W is accepted, then same push/response as above.
- Write with full=1 for 5 cycles -> no write_en or bvalid during stall; write_en 1 cycle after full falls.
- Read araddr=32'hA5A5A5A5, empty=0, read_data=32'hCAFEF00D -> one read_en, rvalid with rdata=32'hCAFEF00D, rresp=00. rready held low 3 cycles -> rvalid/rdata stable throughout.
- Read with empty=1 -> no read_en, rvalid with rdata=0, rresp=10.
- arestn pulsed low during W_PUSH and R_WAIT -> all outputs 0 immediately, no further strobes; readies return 1 cycle after release.
